// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
// One request is outstanding at a time; imem_ack is a single-cycle completion strobe.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC/next-PC selection, single-entry fetch buffer filled over the
// imem bus by an IDLE/REQ/DISCARD FSM, and the instruction register.
module instr_fetch (
  input  logic         CLK,
  input  logic         RST,
  input  logic         PCWre,
  input  logic [1:0]   PCSrc,
  input  logic         IRWre,
  input  logic [31:0]  BrImm,
  input  logic [31:0]  JrAddr,
  instr_fetch_if.master imem,
  output logic [31:0]  PC,
  output logic [31:0]  PC4,
  output logic [31:0]  IR,
  output logic [5:0]   op,
  output logic         FbValid,
  output logic         MissErr
);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t      state;
  logic [31:0] fb;
  logic [31:0] pc_next;
  logic        halt_q;
  logic        halt;

  assign PC4  = PC + 32'd4;
  assign op   = IR[31:26];
  assign halt = halt_q | (op == 6'h3F);

  always_comb begin
    pc_next = PC4;
    case (PCSrc)
      2'b01:   pc_next = PC4 + {BrImm[29:0], 2'b00};
      2'b10:   pc_next = JrAddr;
      2'b11:   pc_next = {PC4[31:28], IR[25:0], 2'b00};
      default: pc_next = PC4;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)       PC <= 32'd0;
    else if (PCWre) PC <= pc_next;
  end

  // IR samples the buffer before any same-edge invalidation, so IRWre+PCWre
  // still delivers the instruction belonging to the old PC.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      IR      <= 32'd0;
      MissErr <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      if (IRWre) begin
        if (FbValid) IR      <= fb;
        else         MissErr <= 1'b1;
      end
      if (op == 6'h3F) halt_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      fb             <= 32'd0;
      FbValid        <= 1'b0;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (PCWre) FbValid <= 1'b0;
          // Fetch from the PC that will be current once this edge has passed.
          if (!FbValid && !halt) begin
            state          <= REQ;
            imem.imem_req  <= 1'b1;
            imem.imem_addr <= PCWre ? pc_next : PC;
          end
        end
        REQ: begin
          if (imem.imem_ack) begin
            fb <= imem.imem_rdata;
            if (!PCWre) FbValid <= 1'b1;
            if (PCWre && !halt) begin
              imem.imem_addr <= pc_next;
            end else begin
              state         <= IDLE;
              imem.imem_req <= 1'b0;
            end
          end else if (PCWre) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (imem.imem_ack) begin
            state         <= IDLE;
            imem.imem_req <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          imem.imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random control traffic, checked against
// an architectural model (PC arithmetic, per-address memory contents, fetch validity).
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        PCWre = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic        IRWre = 1'b0;
  logic [31:0] BrImm = 32'd0;
  logic [31:0] JrAddr = 32'd0;
  logic [31:0] PC, PC4, IR;
  logic [5:0]  op;
  logic        FbValid, MissErr;

  instr_fetch_if imem();

  instr_fetch dut (
    .CLK(CLK), .RST(RST), .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre),
    .BrImm(BrImm), .JrAddr(JrAddr), .imem(imem),
    .PC(PC), .PC4(PC4), .IR(IR), .op(op), .FbValid(FbValid), .MissErr(MissErr)
  );

  always #5 CLK = ~CLK;

  // memory responder
  int          cnt = 0;
  int          lat = 2;
  int          cyc_n = 0;
  int          cur_issue = 0;
  bit          done = 1'b0;
  logic        mack = 1'b0;
  logic        late_ack = 1'b0;
  logic [31:0] rdata_r = 32'd0;
  logic [31:0] cur_addr = 32'd0;
  logic [31:0] ovr [bit [31:0]];

  assign imem.imem_ack   = mack | late_ack;
  assign imem.imem_rdata = rdata_r;

  function automatic logic [31:0] memfn(logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return ((a * 32'h9E3779B1) ^ 32'h5A5A1234) & 32'h7FFFFFFF;
  endfunction

  always @(negedge CLK) begin
    cyc_n++;
    mack = 1'b0;
    rdata_r = $urandom;
    if (!RST || !imem.imem_req || done) cnt = 0;
    done = 1'b0;
    if (RST && imem.imem_req) begin
      cnt++;
      if (cnt == 1) begin
        cur_issue = cyc_n;
        cur_addr  = imem.imem_addr;
      end
      if (cnt > lat) begin
        mack    = 1'b1;
        done    = 1'b1;
        rdata_r = memfn(imem.imem_addr);
      end
    end
  end

  // architectural model
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_ir = 32'd0;
  bit          m_fbv = 1'b0;
  bit          m_miss = 1'b0;
  bit          m_halt = 1'b0;
  int          last_pcw = -1;
  int          stall = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] r;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic [31:0] npc;
    case (PCSrc)
      2'd0:    npc = m_pc + 32'd4;
      2'd1:    npc = m_pc + 32'd4 + BrImm * 32'd4;
      2'd2:    npc = JrAddr;
      default: npc = ((m_pc + 32'd4) & 32'hF0000000) | ((m_ir & 32'h03FFFFFF) * 32'd4);
    endcase
    if (IRWre) begin
      if (m_fbv) m_ir = memfn(m_pc);
      else       m_miss = 1'b1;
    end
    if (m_ir[31:26] == 6'h3F) m_halt = 1'b1;
    // A completed read is usable only if it was issued after the last PC change
    // and targeted the PC that is current now.
    if (PCWre) begin
      m_fbv    = 1'b0;
      last_pcw = cyc_n;
      m_pc     = npc;
      stall    = 0;
    end else if (mack && cur_issue > last_pcw && cur_addr == m_pc) begin
      m_fbv = 1'b1;
    end
  endtask

  task automatic check();
    chk("PC", PC, m_pc);
    chk("PC4", PC4, m_pc + 32'd4);
    chk("IR", IR, m_ir);
    chk("op", {26'd0, op}, {26'd0, m_ir[31:26]});
    chk("FbValid", {31'd0, FbValid}, {31'd0, m_fbv});
    chk("MissErr", {31'd0, MissErr}, {31'd0, m_miss});
    if (cnt > 1) chk("addr_hold", imem.imem_addr, cur_addr);
    if (m_halt) chk("halt_noreq", {31'd0, (cnt == 1)}, 32'd0);
    if (m_halt || m_fbv) stall = 0;
    else stall++;
    chk("fetch_live", {31'd0, (stall > 24)}, 32'd0);
  endtask

  // One clock: inputs are already set for the coming edge; compare just after the next negedge.
  task automatic step();
    model_update();
    @(negedge CLK);
    #1;
    check();
    PCWre = 1'b0;
    IRWre = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #2;
    m_pc = 32'd0; m_ir = 32'd0; m_fbv = 1'b0; m_miss = 1'b0; m_halt = 1'b0; stall = 0;
    chk("rst_PC", PC, 32'd0);
    chk("rst_IR", IR, 32'd0);
    chk("rst_FbValid", {31'd0, FbValid}, 32'd0);
    chk("rst_MissErr", {31'd0, MissErr}, 32'd0);
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    @(negedge CLK);
    #1;
    RST = 1'b1;
  endtask

  task automatic wait_fbv(string tag);
    for (int i = 0; i < 24 && !m_fbv; i++) step();
    chk(tag, {31'd0, FbValid}, 32'd1);
  endtask

  initial begin
    @(negedge CLK);
    #1;
    ovr[32'h0]  = 32'hE0000010;
    ovr[32'h10] = 32'hE0000040;

    // first fetch after reset, memory answers 2 cycles after the request
    lat = 2;
    do_reset();
    step();
    chk("first_req", {31'd0, imem.imem_req}, 32'd1);
    chk("first_addr", imem.imem_addr, 32'd0);
    wait_fbv("fb_after_ack");
    IRWre = 1'b1; step();
    chk("ir_load", IR, 32'hE0000010);
    chk("op_load", {26'd0, op}, 32'h38);

    // jumps and branches
    PCSrc = 2'd2; JrAddr = 32'h10; PCWre = 1'b1; step();
    chk("jr_0x10", PC, 32'h10);
    wait_fbv("fb_0x10");
    IRWre = 1'b1; step();
    chk("ir_0x10", IR, 32'hE0000040);
    PCSrc = 2'd3; PCWre = 1'b1; step();
    chk("j_abs", PC, 32'h100);
    PCSrc = 2'd1; BrImm = 32'hFFFFFFFE; PCWre = 1'b1; step();
    chk("branch_back", PC, 32'hFC);
    PCSrc = 2'd2; JrAddr = 32'h200; PCWre = 1'b1; step();
    chk("jr_0x200", PC, 32'h200);
    JrAddr = 32'hFFFFFFFC; PCWre = 1'b1; step();
    PCSrc = 2'd0; PCWre = 1'b1; step();
    chk("pc_wrap", PC, 32'h0);

    // IR load while the buffer is empty
    do_reset();
    IRWre = 1'b1; step();
    chk("miss_set", {31'd0, MissErr}, 32'd1);
    chk("miss_ir", IR, 32'd0);
    repeat (5) step();
    chk("miss_sticky", {31'd0, MissErr}, 32'd1);

    // PC change while the fetch of 0x4 is pending
    lat = 3;
    wait_fbv("fb_0");
    PCSrc = 2'd2; JrAddr = 32'h4; PCWre = 1'b1; step();
    for (int i = 0; i < 8 && cnt != 1; i++) step();
    chk("req_0x4", imem.imem_addr, 32'h4);
    JrAddr = 32'h40; PCWre = 1'b1; step();
    chk("hold_req", {31'd0, imem.imem_req}, 32'd1);
    chk("hold_0x4", imem.imem_addr, 32'h4);
    for (int i = 0; i < 12 && !(cnt == 1 && cur_addr != 32'h4); i++) step();
    chk("refetch_addr", imem.imem_addr, 32'h40);
    chk("stale_dropped", {31'd0, FbValid}, 32'd0);
    wait_fbv("fb_0x40");
    IRWre = 1'b1; step();
    chk("ir_0x40", IR, memfn(32'h40));

    // reset in the middle of a request, then a late ack while idle
    PCSrc = 2'd2; JrAddr = 32'h80; PCWre = 1'b1; step();
    step();
    chk("pre_reset_req", {31'd0, imem.imem_req}, 32'd1);
    do_reset();
    late_ack = 1'b1; step();
    late_ack = 1'b0;
    chk("restart_req", {31'd0, imem.imem_req}, 32'd1);
    chk("restart_addr", imem.imem_addr, 32'd0);
    chk("late_ack_ignored", {31'd0, FbValid}, 32'd0);

    // random control traffic
    for (int k = 0; k < 300; k++) begin
      r      = $urandom;
      PCWre  = (r[2:0] < 3'd2);
      IRWre  = (r[5:3] < 3'd3);
      PCSrc  = r[9:8];
      BrImm  = {{16{r[31]}}, r[31:16]};
      JrAddr = $urandom & ~32'd3;
      if (cnt == 0 && r[12:10] == 3'd0) lat = $urandom_range(0, 3);
      step();
    end

    // halt instruction stops fetching until reset
    ovr[32'h300] = 32'hFC000000;
    PCSrc = 2'd2; JrAddr = 32'h300; PCWre = 1'b1; step();
    wait_fbv("fb_halt");
    IRWre = 1'b1; step();
    chk("halt_op", {26'd0, op}, 32'h3F);
    PCSrc = 2'd0; PCWre = 1'b1; step();
    repeat (12) step();
    chk("halt_no_req", {31'd0, imem.imem_req}, 32'd0);
    chk("halt_fb_empty", {31'd0, FbValid}, 32'd0);
    do_reset();
    step();
    chk("unhalt_req", {31'd0, imem.imem_req}, 32'd1);
    chk("unhalt_addr", imem.imem_addr, 32'd0);
    wait_fbv("fb_unhalt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 CLK  in  1  system clock; all state SHALL update on the rising edge.
REQ-002 RST  in  1  reset; SHALL be asynchronous and active-low (0 = reset).
REQ-003 PCWre  in  1  PC write enable from the control unit.
REQ-004 PCSrc  in  2  next-PC select: 00 PC+4, 01 branch, 10 register jump (JR), 11 absolute jump (J/JAL).
REQ-005 IRWre  in  1  instruction register load enable from the control unit.
REQ-006 BrImm  in  32  sign-extended 16-bit branch offset, in words.
REQ-007 JrAddr  in  32  rs register value used as the JR target.
REQ-008 imem_req  out  1  instruction memory read request.
REQ-009 imem_addr  out  32  instruction memory byte address.
REQ-010 imem_ack  in  1  one-cycle read completion strobe.
REQ-011 imem_rdata  in  32  read data; valid only while imem_ack=1.
REQ-012 PC  out  32  current program counter.
REQ-013 PC4  out  32  PC+4; return-address source for JAL.
REQ-014 IR  out  32  instruction register.
REQ-015 op  out  6  IR[31:26], feeds control-unit op.
REQ-016 FbValid  out  1  fetch buffer holds the instruction at the current PC.
REQ-017 MissErr  out  1  sticky flag: IRWre arrived while FbValid=0.

Function
REQ-018 PC4 SHALL be PC+4 modulo 2^32, combinational.
REQ-019 Next PC by PCSrc: 00 PC4; 01 PC4+(BrImm<<2), wrapping mod 2^32; 10 JrAddr; 11 {PC4[31:28], IR[25:0], 2'b00}.
REQ-020 PC SHALL load next PC on the rising edge only when PCWre=1; otherwise it holds.
REQ-021 The fetch FSM SHALL use states IDLE, REQ and DISCARD.
REQ-022 IDLE: when FbValid=0 and the block is not halted, go to REQ next cycle with imem_req=1 and imem_addr=PC.
REQ-023 REQ: imem_req and imem_addr SHALL hold stable until imem_ack=1.
REQ-024 REQ on ack: latch imem_rdata into the fetch buffer, set FbValid=1, return to IDLE.
REQ-025 If PCWre=1 in the same cycle as ack, the data SHALL be latched as stale, FbValid SHALL stay 0, and a new fetch SHALL be issued.
REQ-026 PCWre=1 while in REQ without ack: go to DISCARD; the bus request stays asserted at the old address until ack.
REQ-027 DISCARD on ack: drop the data, go to IDLE; a refetch from the new PC follows.
REQ-028 PCWre=1 in IDLE SHALL clear FbValid on the same edge.
REQ-029 IRWre=1 with FbValid=1 SHALL copy the buffer to IR on the edge.
REQ-030 IRWre=1 with FbValid=0: IR holds and MissErr sets; MissErr clears only on reset.
REQ-031 IRWre and PCWre in the same cycle with FbValid=1: IR SHALL take the buffer for the old PC, then the buffer is invalidated.
REQ-032 Halt: when op=6'b111111, no new request SHALL issue; an outstanding request SHALL complete normally.
REQ-033 Halt ends only on reset.
REQ-034 imem_req SHALL be 1 only in REQ or DISCARD.
REQ-035 At most one memory request SHALL be outstanding at a time.

Reset
REQ-036 RST=0 SHALL asynchronously force: PC=0, IR=0, fetch buffer=0, FbValid=0, MissErr=0, FSM=IDLE, imem_req=0.
REQ-037 The first request after RST rises SHALL issue at address 0x00000000 within 1 cycle.
REQ-038 Reset mid-request SHALL abandon the request; a late ack arriving in IDLE SHALL be ignored.

Verification
REQ-039 Reset release, memory acks 2 cycles after request with 0xE0000010 -> imem_addr=0, FbValid=1 after ack; IRWre -> IR=0xE0000010, op=6'b111000.
REQ-040 PC=0x100, BrImm=0xFFFFFFFE, PCSrc=01, PCWre -> PC=0xFC; wrap case PC=0xFFFFFFFC, PCSrc=00 -> PC=0.
REQ-041 IR=0xE0000040, PC=0x10, PCSrc=11 -> PC=0x100; PCSrc=10, JrAddr=0x200 -> PC=0x200.
REQ-042 PCWre during a pending fetch of 0x4 (ack delayed 3 cycles) -> request held at 0x4, data dropped, next request at the new PC, FbValid set only from the new PC's data.
REQ-043 IRWre with FbValid=0 -> IR unchanged, MissErr=1 sticky until RST=0.
REQ-044 IR op=111111 -> no further imem_req; RST pulse -> fetching restarts at 0.
